// File: rtl/gw2a_ddr_rdcap_pkg.sv
// Shared constants and types for the GW2A DDR read-capture stage.
// Burst geometry, minimum latency, expected strobe pattern and capture FSM states.
package gw2a_ddr_rdcap_pkg;

    localparam int unsigned BURST_LEN      = 8;
    localparam int unsigned BEATS_PER_PCLK = 2;
    localparam int unsigned CAP_CYCLES     = BURST_LEN / BEATS_PER_PCLK;
    localparam int unsigned RDLAT_MIN      = 2;

    // DQS sampled as high on the first beat and low on the second when read timing is centred
    localparam logic DQS_EXP_Q0 = 1'b1;
    localparam logic DQS_EXP_Q1 = 1'b0;

    // Requests closer than this many cycles to the previous accepted one would overlap its burst
    localparam int unsigned OVL_WINDOW = CAP_CYCLES - 1;

    typedef enum logic [0:0] {
        StIdle,
        StCap
    } cap_state_e;

    function automatic int unsigned eff_lat(input int unsigned lat);
        return (lat < RDLAT_MIN) ? RDLAT_MIN : lat;
    endfunction

endpackage

// File: rtl/gw2a_ddr_rdcap_collect.sv
// Burst collector: beat counter, beat assembly shift register and strobe-pattern checker.
// Reports a completed burst combinationally on the last capture cycle.
module ddr_burst_collect
    import gw2a_ddr_rdcap_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       dqs_q0_i,
    input  logic                       dqs_q1_i,
    input  logic [WIDTH-1:0]           dq_q0_i,
    input  logic [WIDTH-1:0]           dq_q1_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       done_err_o,
    output logic [BURST_LEN*WIDTH-1:0] burst_o
);

    localparam int unsigned AsmW    = (BURST_LEN - BEATS_PER_PCLK) * WIDTH;
    localparam logic [1:0]  LastCnt = 2'(CAP_CYCLES - 1);

    cap_state_e         state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [AsmW-1:0]    asm_q, asm_d;
    logic               err_q, err_d;
    logic               strobe_bad;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        err_d      = err_q;
        done_o     = 1'b0;
        done_err_o = 1'b0;
        strobe_bad = (dqs_q0_i != DQS_EXP_Q0) || (dqs_q1_i != DQS_EXP_Q1);
        // The final beat pair goes straight to the output register without passing asm_q
        burst_o    = {dq_q1_i, dq_q0_i, asm_q};

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StCap;
                    cnt_d   = 2'd0;
                    err_d   = 1'b0;
                end
            end
            StCap: begin
                if (cnt_q == LastCnt) begin
                    done_o     = 1'b1;
                    done_err_o = err_q | strobe_bad;
                    cnt_d      = 2'd0;
                    err_d      = 1'b0;
                    state_d    = start_i ? StCap : StIdle;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                    err_d = err_q | strobe_bad;
                    asm_d = {dq_q1_i, dq_q0_i, asm_q[AsmW-1:2*WIDTH]};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            asm_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
        end
    end

    assign busy_o = (state_q == StCap);

endmodule

// File: rtl/gw2a_ddr_rdcap.sv
// GW2A DDR read capture: times BL8 bursts against read requests and assembles them into one word.
// Holds the request token pipe, the request spacing guard and the output registers.
module gw2a_ddr_rdcap
    import gw2a_ddr_rdcap_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned LAT_BITS = 4
) (
    input  logic                       PCLK,
    input  logic                       RESET_N,
    input  logic                       RD_REQ,
    input  logic [LAT_BITS-1:0]        RD_LAT,
    input  logic                       DQS_Q0,
    input  logic                       DQS_Q1,
    input  logic [WIDTH-1:0]           DQ_Q0,
    input  logic [WIDTH-1:0]           DQ_Q1,
    output logic                       RD_VALID,
    output logic [BURST_LEN*WIDTH-1:0] RD_DATA,
    output logic                       RD_ERR,
    output logic                       OVERLAP,
    output logic                       BUSY
);

    localparam int unsigned Depth = 2 ** LAT_BITS;

    logic [Depth-1:0]           pipe_q, pipe_d;
    logic [1:0]                 gap_q, gap_d;
    logic                       overlap_q, overlap_d;
    logic                       rd_valid_q, rd_valid_d;
    logic                       rd_err_q, rd_err_d;
    logic [BURST_LEN*WIDTH-1:0] rd_data_q, rd_data_d;

    logic                       req_ok;
    int unsigned                tap_u;
    logic [LAT_BITS-1:0]        tap;
    logic                       cap_start;
    logic                       cap_busy;
    logic                       cap_done;
    logic                       cap_done_err;
    logic [BURST_LEN*WIDTH-1:0] cap_burst;

    always_comb begin
        // Token sits at stage k during cycle t+k+1; tapping L-2 lets the collector enter
        // its capture state exactly at cycle t+L.
        tap_u     = eff_lat(32'(RD_LAT)) - RDLAT_MIN;
        tap       = LAT_BITS'(tap_u);
        cap_start = pipe_q[tap];

        req_ok    = RD_REQ && (gap_q == 2'd0);
        overlap_d = RD_REQ && (gap_q != 2'd0);

        gap_d = gap_q;
        if (req_ok) begin
            gap_d = 2'(OVL_WINDOW);
        end else if (gap_q != 2'd0) begin
            gap_d = gap_q - 2'd1;
        end

        // Tokens are dropped once past the tap so BUSY reflects only live requests
        pipe_d    = '0;
        pipe_d[0] = req_ok;
        for (int unsigned i = 1; i < Depth; i++) begin
            if (i <= tap_u) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        rd_valid_d = cap_done;
        rd_err_d   = cap_done & cap_done_err;
        rd_data_d  = cap_done ? cap_burst : rd_data_q;
    end

    ddr_burst_collect #(
        .WIDTH(WIDTH)
    ) u_collect (
        .clk_i      (PCLK),
        .rst_ni     (RESET_N),
        .start_i    (cap_start),
        .dqs_q0_i   (DQS_Q0),
        .dqs_q1_i   (DQS_Q1),
        .dq_q0_i    (DQ_Q0),
        .dq_q1_i    (DQ_Q1),
        .busy_o     (cap_busy),
        .done_o     (cap_done),
        .done_err_o (cap_done_err),
        .burst_o    (cap_burst)
    );

    always_ff @(posedge PCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pipe_q     <= '0;
            gap_q      <= 2'd0;
            overlap_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            pipe_q     <= pipe_d;
            gap_q      <= gap_d;
            overlap_q  <= overlap_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign RD_VALID = rd_valid_q;
    assign RD_ERR   = rd_err_q;
    assign RD_DATA  = rd_data_q;
    assign OVERLAP  = overlap_q;
    assign BUSY     = (|pipe_q) | cap_busy;

endmodule

// File: tb/tb_gw2a_ddr_rdcap.sv
// Self-checking bench for gw2a_ddr_rdcap: request table plus hand sequences, scoreboarded outputs.
module tb_gw2a_ddr_rdcap;

    localparam int W = 16;
    localparam int DW = 8 * W;

    logic          PCLK = 1'b0;
    logic          RESET_N;
    logic          RD_REQ;
    logic [3:0]    RD_LAT;
    logic          DQS_Q0, DQS_Q1;
    logic [W-1:0]  DQ_Q0, DQ_Q1;
    logic          RD_VALID, RD_ERR, OVERLAP, BUSY;
    logic [DW-1:0] RD_DATA;

    gw2a_ddr_rdcap #(.WIDTH(W), .LAT_BITS(4)) dut (
        .PCLK     (PCLK),
        .RESET_N  (RESET_N),
        .RD_REQ   (RD_REQ),
        .RD_LAT   (RD_LAT),
        .DQS_Q0   (DQS_Q0),
        .DQS_Q1   (DQS_Q1),
        .DQ_Q0    (DQ_Q0),
        .DQ_Q1    (DQ_Q1),
        .RD_VALID (RD_VALID),
        .RD_DATA  (RD_DATA),
        .RD_ERR   (RD_ERR),
        .OVERLAP  (OVERLAP),
        .BUSY     (BUSY)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int            acc;
        int            vcyc;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    typedef struct {
        int lat;
        int nreq;
        int gap;
        int bad_off;
    } vec_t;

    exp_t exp_q[$];
    int   ov_q[$];
    int   cyc = 0;
    int   pat_base = 0;
    int   bad_cyc = -1;
    int   last_acc = -100;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic logic [W-1:0] pat(input int c, input int h);
        return W'((c - pat_base) * 2 + h + 1);
    endfunction

    function automatic int eff(input int lat);
        return (lat < 2) ? 2 : lat;
    endfunction

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // DQ/DQS IOB model: deterministic data per cycle, strobe corrupted on bad_cyc
    always @(posedge PCLK) begin
        #1;
        DQ_Q0  = pat(cyc, 0);
        DQ_Q1  = pat(cyc, 1);
        DQS_Q0 = (cyc == bad_cyc) ? 1'b0 : 1'b1;
        DQS_Q1 = 1'b0;
    end

    always @(negedge PCLK) begin
        exp_t e;
        logic eb;
        eb = 1'b0;
        foreach (exp_q[i]) if (cyc > exp_q[i].acc && cyc < exp_q[i].vcyc) eb = 1'b1;
        check("busy", DW'(BUSY), DW'(eb));
        if (RD_VALID) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", DW'(RD_VALID), DW'(0));
            end else begin
                e = exp_q.pop_front();
                check("valid_cycle", DW'(cyc), DW'(e.vcyc));
                check("rd_data", RD_DATA, e.data);
                check("rd_err", DW'(RD_ERR), DW'(e.err));
            end
        end else begin
            check("err_unqualified", DW'(RD_ERR), DW'(0));
            if (exp_q.size() != 0 && exp_q[0].vcyc <= cyc) begin
                e = exp_q.pop_front();
                check("missing_valid", DW'(RD_VALID), DW'(1));
            end
        end
        if (OVERLAP) begin
            if (ov_q.size() == 0 || ov_q[0] != cyc) check("unexpected_overlap", DW'(OVERLAP), DW'(0));
            else void'(ov_q.pop_front());
        end else if (ov_q.size() != 0 && ov_q[0] <= cyc) begin
            void'(ov_q.pop_front());
            check("missing_overlap", DW'(OVERLAP), DW'(1));
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Drive RD_REQ for the current cycle and predict its outcome
    task automatic do_req();
        exp_t e;
        int   t;
        int   l;
        t = cyc;
        l = eff(int'(RD_LAT));
        RD_REQ = 1'b1;
        if (t - last_acc >= 4) begin
            last_acc = t;
            e.acc  = t;
            e.vcyc = t + l + 4;
            e.err  = (bad_cyc >= t + l) && (bad_cyc <= t + l + 3);
            for (int k = 0; k < 4; k++) begin
                e.data[32*k +: 16]      = pat(t + l + k, 0);
                e.data[32*k + 16 +: 16] = pat(t + l + k, 1);
            end
            exp_q.push_back(e);
        end else begin
            ov_q.push_back(t + 1);
        end
        tick();
        RD_REQ = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ov_q.size() != 0 || BUSY) && n < 80) begin
            tick();
            n++;
        end
        check("drain_timeout", DW'(n >= 80), DW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[10];
        logic [DW-1:0] t1_data;
        int            t;

        vecs[0] = '{lat: 5,  nreq: 1, gap: 4, bad_off: -1};
        vecs[1] = '{lat: 3,  nreq: 4, gap: 4, bad_off: -1};
        vecs[2] = '{lat: 3,  nreq: 2, gap: 2, bad_off: -1};
        vecs[3] = '{lat: 4,  nreq: 2, gap: 5, bad_off: 2};
        vecs[4] = '{lat: 0,  nreq: 1, gap: 4, bad_off: -1};
        vecs[5] = '{lat: 1,  nreq: 2, gap: 4, bad_off: -1};
        vecs[6] = '{lat: 15, nreq: 3, gap: 4, bad_off: -1};
        vecs[7] = '{lat: 2,  nreq: 4, gap: 4, bad_off: 0};
        vecs[8] = '{lat: 7,  nreq: 3, gap: 1, bad_off: -1};
        vecs[9] = '{lat: 2,  nreq: 2, gap: 3, bad_off: 3};
        t1_data = 128'h0008_0007_0006_0005_0004_0003_0002_0001;

        RESET_N = 1'b0;
        RD_REQ  = 1'b0;
        RD_LAT  = 4'd5;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("reset_valid", DW'(RD_VALID), DW'(0));
        check("reset_data", RD_DATA, DW'(0));
        check("reset_err", DW'(RD_ERR), DW'(0));
        check("reset_overlap", DW'(OVERLAP), DW'(0));
        check("reset_busy", DW'(BUSY), DW'(0));
        tick();
        RESET_N = 1'b1;

        // Single burst at t=10, latency 5, beats 1..8
        pat_base = 15;
        while (cyc < 10) tick();
        do_req();
        while (cyc < 19) tick();
        @(negedge PCLK);
        check("t1_valid", DW'(RD_VALID), DW'(1));
        check("t1_data", RD_DATA, t1_data);
        tick();
        wait_idle();
        pat_base = 0;

        for (int i = 0; i < 10; i++) begin
            RD_LAT  = 4'(vecs[i].lat);
            bad_cyc = -1;
            for (int k = 0; k < vecs[i].nreq; k++) begin
                if (k == 0 && vecs[i].bad_off >= 0) bad_cyc = cyc + eff(vecs[i].lat) + vecs[i].bad_off;
                do_req();
                repeat (vecs[i].gap - 1) tick();
            end
            wait_idle();
            tick();
        end
        bad_cyc = -1;

        // Reset during the second capture cycle discards the burst
        RD_LAT = 4'd3;
        t = cyc;
        do_req();
        while (cyc < t + 4) tick();
        RESET_N = 1'b0;
        exp_q.delete();
        ov_q.delete();
        last_acc = -100;
        #1;
        check("rst_mid_valid", DW'(RD_VALID), DW'(0));
        check("rst_mid_data", RD_DATA, DW'(0));
        check("rst_mid_busy", DW'(BUSY), DW'(0));
        check("rst_mid_err", DW'(RD_ERR), DW'(0));
        tick();
        tick();
        RESET_N = 1'b1;
        repeat (20) tick();
        check("post_rst_busy", DW'(BUSY), DW'(0));
        do_req();
        wait_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
